elastic_reg_pipe: RTL

Parametrised elastic register pipeline: a WIDTH-bit data path through DEPTH register stages, each with its own valid bit and valid/ready handshake on both ends. It adds global clock enable (SP-style) and synchronous flush (CD-style) to the single-bit enable/clear flop, plus bubble collapsing and backpressure. It sits between streaming blocks (camera/SPI/ML datapaths) wherever a retiming or latency-matching stage is needed.

---
 rtl/elastic_reg_pipe.sv | 98 +++++++++
 1 files changed

// File: rtl/elastic_reg_pipe.sv
// rtl/elastic_reg_pipe.sv - elastic valid/ready register pipeline with clock enable, flush and bubble collapse
// Optional occupancy counter and port: define ELASTIC_REG_PIPE_OCCUPANCY_EN.
module elastic_reg_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef ELASTIC_REG_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] vin;
    logic [WIDTH-1:0] din [DEPTH];
    logic             adv_acc;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        adv     = '0;
        adv_acc = m_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv_acc = adv_acc | ~v[k];
            adv[k]  = adv_acc;
        end
    end

    always_comb begin
        vin    = '0;
        vin[0] = s_valid;
        din[0] = s_data;
        for (int k = 1; k < DEPTH; k++) begin
            vin[k] = v[k-1];
            din[k] = d[k-1];
        end
    end

    assign s_ready = ce & ~flush & adv[0];
    assign m_valid = ce & ~flush & v[DEPTH-1];
    assign m_data  = d[DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= RESET_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else if (ce) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v[k] <= vin[k];
                    // Data only moves with a real word so bubbles leave registers untouched.
                    if (vin[k]) begin
                        d[k] <= din[k];
                    end
                end
            end
        end
    end

`ifdef ELASTIC_REG_PIPE_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer   = s_valid & s_ready;
    assign out_xfer  = m_valid & m_ready;
    assign occupancy = occ;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            occ <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ <= occ + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ <= occ - OCC_W'(1);
        end
    end
`endif

endmodule
